// File: rtl/bypass_seq_ctrl.sv
// bypass_seq_ctrl: H-bridge bypass contactor sequencer (gate block, dwell, close, feedback confirm)
// Define BYPASS_FB_CHECK_EN to build the contactor feedback check, timeout and FAIL state.
module bypass_seq_ctrl #(
  parameter int BLOCK_TICKS = 5,
  parameter int CLOSE_TICKS = 100,
  parameter int FB_TIMEOUT  = 50,
  parameter int FB_DEB      = 3
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tick,
  input  logic       call_fault,
  input  logic       bypass_cmd,
  input  logic       clr,
  input  logic       bypass_fb,
  output logic       gate_block,
  output logic       bypass_o,
  output logic       bypassed,
  output logic       fb_fail,
  output logic [2:0] state
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BLOCK = 3'd1,
    DWELL = 3'd2,
    CLOSE = 3'd3,
    DONE  = 3'd4,
    FAIL  = 3'd5
  } st_t;
  st_t st, nxt;
  logic [15:0] tcnt;
  logic trig, abort, fb_ok, fb_to, gate_d, coil_d, done_d, fail_d;
  assign trig  = call_fault | bypass_cmd;
  assign abort = clr & ~trig;
  assign state = st;
`ifdef BYPASS_FB_CHECK_EN
  localparam int FW = $clog2(FB_DEB + 1);
  localparam logic [FW-1:0] DEB = FW'(FB_DEB);
  logic fb_s1, fb_s2;
  logic [FW-1:0] fb_cnt;
  // Debounce runs on ticks, so a bouncing aux contact needs FB_DEB quiet ticks in a row.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      fb_s1  <= 1'b1;
      fb_s2  <= 1'b1;
      fb_cnt <= '0;
    end else begin
      fb_s1 <= bypass_fb;
      fb_s2 <= fb_s1;
      if (tick) fb_cnt <= fb_s2 ? '0 : (fb_cnt == DEB) ? fb_cnt : fb_cnt + 1'b1;
    end
  assign fb_ok  = fb_cnt == DEB;
  assign fb_to  = tick && tcnt == 16'(FB_TIMEOUT - 1);
  assign fail_d = st == FAIL;
`else
  logic unused_fb;
  assign unused_fb = bypass_fb ^ (FB_TIMEOUT > 0) ^ (FB_DEB > 0);
  assign fb_ok  = 1'b1;
  assign fb_to  = 1'b0;
  assign fail_d = 1'b0;
`endif
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      st   <= IDLE;
      tcnt <= '0;
    end else begin
      st   <= nxt;
      tcnt <= (nxt != st) ? '0 : tcnt + 16'(tick);
    end
  // Once the coil is driven only rstn can release it; clr is honoured only before CLOSE.
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = trig ? BLOCK : IDLE;
      BLOCK:   nxt = abort ? IDLE : (tick && tcnt == 16'(BLOCK_TICKS - 1)) ? DWELL : BLOCK;
      DWELL:   nxt = abort ? IDLE : (tick && tcnt == 16'(CLOSE_TICKS - 1)) ? CLOSE : DWELL;
      CLOSE:   nxt = fb_ok ? DONE : fb_to ? FAIL : CLOSE;
      FAIL:    nxt = fb_ok ? DONE : FAIL;
      DONE:    nxt = DONE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    gate_d = st != IDLE;
    coil_d = st == CLOSE || st == FAIL || st == DONE;
    done_d = st == DONE;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      gate_block <= 1'b0;
      bypass_o   <= 1'b0;
      bypassed   <= 1'b0;
      fb_fail    <= 1'b0;
    end else begin
      gate_block <= gate_d;
      bypass_o   <= coil_d;
      bypassed   <= done_d;
      fb_fail    <= fb_fail | fail_d;
    end
endmodule
